// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, picks the next fetch address,
// screens it for AdEL and hands instruction/PC/ExcCode/delay-slot flag to IF/ID.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_TOP    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        is_ctrl_d,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  excode_o,
  output logic        bd_o,
  output logic [31:0] fetch_cnt
);

  localparam logic [6:0] EXC_ADEL = 7'd4;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] fetch_cnt_reg;
  logic        adel;
  logic        flush;

  // CP0 redirects beat the hazard stall; ID redirects wait for it to clear.
  always_comb begin
    pc_next = pc_reg;
    if (exc_req)       pc_next = EXC_ENTRY;
    else if (eret)     pc_next = epc;
    else if (stall)    pc_next = pc_reg;
    else if (jr)       pc_next = jr_target;
    else if (jmp)      pc_next = jmp_target;
    else if (br_taken) pc_next = br_target;
    else               pc_next = pc_reg + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg        <= PC_RESET;
      fetch_cnt_reg <= 32'd0;
    end else begin
      pc_reg <= pc_next;
      if (!stall && !exc_req && !eret)
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
    end
  end

  assign flush = exc_req | eret;
  assign adel  = (pc_reg[1:0] != 2'b00) || (pc_reg < IM_BASE) || (pc_reg > IM_TOP);

  // Memory is still addressed on AdEL; its data is replaced by a nop.
  assign im_addr   = pc_reg;
  assign pc_o      = pc_reg;
  assign instr_o   = adel ? 32'h0 : im_rdata;
  assign excode_o  = adel ? EXC_ADEL : 7'd0;
  assign bd_o      = is_ctrl_d & ~flush;
  assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequences and
// randomized cycles against a next-PC model built from the priority rules.
module tb_fetch_stage;

  localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset, stall, exc_req, eret, br_taken, jmp, jr, is_ctrl_d;
  logic [31:0] epc, br_target, jmp_target, jr_target;
  logic [31:0] im_addr, im_rdata, instr_o, pc_o, fetch_cnt;
  logic [6:0]  excode_o;
  logic        bd_o;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req), .eret(eret),
    .epc(epc), .br_taken(br_taken), .br_target(br_target), .jmp(jmp),
    .jmp_target(jmp_target), .jr(jr), .jr_target(jr_target), .is_ctrl_d(is_ctrl_d),
    .im_addr(im_addr), .im_rdata(im_rdata), .instr_o(instr_o), .pc_o(pc_o),
    .excode_o(excode_o), .bd_o(bd_o), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in: data is a fixed function of the address.
  assign im_rdata = im_addr ^ MEM_KEY;

  typedef struct {
    logic        stall, exc, eret, br, jmp, jr, ctrl;
    logic [31:0] epc, br_t, j_t, jr_t;
    logic [31:0] exp_pc, exp_cnt;
    logic        exp_bd;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic s, input logic x, input logic e, input logic b,
                              input logic j, input logic r, input logic c,
                              input logic [31:0] ep, input logic [31:0] bt,
                              input logic [31:0] jt, input logic [31:0] rt,
                              input logic [31:0] xp, input logic [31:0] xc, input logic xb);
    vec_t v;
    v.stall = s; v.exc = x; v.eret = e; v.br = b; v.jmp = j; v.jr = r; v.ctrl = c;
    v.epc = ep; v.br_t = bt; v.j_t = jt; v.jr_t = rt;
    v.exp_pc = xp; v.exp_cnt = xc; v.exp_bd = xb;
    return v;
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a <= 32'h6FFC);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic s, input logic x, input logic e, input logic b,
                       input logic j, input logic r, input logic c,
                       input logic [31:0] ep, input logic [31:0] bt,
                       input logic [31:0] jt, input logic [31:0] rt);
    stall = s; exc_req = x; eret = e; br_taken = b; jmp = j; jr = r; is_ctrl_d = c;
    epc = ep; br_target = bt; jmp_target = jt; jr_target = rt;
  endtask

  // Compare the registered state and the combinational IF outputs that follow from it.
  task automatic check_state(input string tag, input logic [31:0] xp, input logic [31:0] xc);
    check({tag, " pc_o"}, pc_o, xp);
    check({tag, " fetch_cnt"}, fetch_cnt, xc);
    check({tag, " excode_o"}, {25'd0, excode_o}, legal(xp) ? 32'd0 : 32'd4);
    check({tag, " instr_o"}, instr_o, legal(xp) ? (xp ^ MEM_KEY) : 32'h0);
  endtask

  logic [31:0] m_pc, m_cnt;
  logic        r_rst, r_exc, r_eret, r_stall, r_br, r_jmp, r_jr, r_ctrl;
  logic [31:0] r_epc, r_bt, r_jt, r_jrt;

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'h3000 + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC);
  endfunction

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("reset", 32'h3000, 32'd0);
    check("reset bd_o", {31'd0, bd_o}, 32'd0);

    //             s  x  e  b  j  r  c  epc       br_t      j_t       jr_t      exp_pc    cnt bd
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,        0,        0,        0,        32'h3004, 1,  0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,        0,        0,        0,        32'h3008, 2,  0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,        0,        0,        0,        32'h300C, 3,  0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,        0,        0,        0,        32'h3010, 4,  0);
    vecs[4]  = mk(1, 0, 0, 1, 0, 0, 1, 0,        32'h3100, 0,        0,        32'h3010, 4,  1);
    vecs[5]  = mk(1, 0, 0, 1, 0, 0, 1, 0,        32'h3100, 0,        0,        32'h3010, 4,  1);
    vecs[6]  = mk(1, 0, 0, 1, 0, 0, 1, 0,        32'h3100, 0,        0,        32'h3010, 4,  1);
    vecs[7]  = mk(0, 0, 0, 1, 0, 0, 1, 0,        32'h3100, 0,        0,        32'h3100, 5,  1);
    vecs[8]  = mk(0, 0, 0, 1, 0, 1, 0, 0,        32'h3300, 0,        32'h3200, 32'h3200, 6,  0);
    vecs[9]  = mk(0, 0, 0, 0, 1, 0, 0, 0,        0,        32'h3400, 0,        32'h3400, 7,  0);
    vecs[10] = mk(1, 1, 1, 0, 0, 0, 1, 32'h3000, 0,        0,        0,        32'h4180, 7,  0);
    vecs[11] = mk(0, 0, 1, 0, 0, 0, 0, 32'h3002, 0,        0,        0,        32'h3002, 7,  0);
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 0, 0,        0,        0,        32'h6FF8, 32'h6FF8, 8,  0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,        0,        0,        0,        32'h6FFC, 9,  0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,        0,        0,        0,        32'h7000, 10, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 0,        0,        0,        0,        32'h7004, 11, 1);
    vecs[16] = mk(0, 0, 1, 0, 0, 0, 1, 32'h3000, 0,        0,        0,        32'h3000, 11, 0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].stall, vecs[i].exc, vecs[i].eret, vecs[i].br, vecs[i].jmp, vecs[i].jr,
            vecs[i].ctrl, vecs[i].epc, vecs[i].br_t, vecs[i].j_t, vecs[i].jr_t);
      #1;
      check($sformatf("vec%0d bd_o", i), {31'd0, bd_o}, {31'd0, vecs[i].exp_bd});
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_cnt);
      $display("vec %0d: pc_o=%h fetch_cnt=%0d excode_o=%0d", i, pc_o, fetch_cnt, excode_o);
      @(negedge clk);
    end

    // Reset while stalled with a redirect pending drops the redirect.
    drive(1, 0, 0, 1, 0, 0, 0, 0, 32'h3500, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_state("mid reset", 32'h3000, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_state("post reset", 32'h3004, 32'd1);
    $display("seq reset: pc_o=%h fetch_cnt=%0d", pc_o, fetch_cnt);

    // Sequential PC wraps from the top of the address space to 0 (AdEL).
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check_state("wrap top", 32'hFFFF_FFFC, 32'd2);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_state("wrap zero", 32'h0, 32'd3);
    $display("seq wrap: pc_o=%h excode_o=%0d", pc_o, excode_o);

    // Randomized cycles against the model.
    m_pc  = 32'h0;
    m_cnt = 32'd3;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      r_rst   = ($urandom_range(0, 31) == 0);
      r_exc   = ($urandom_range(0, 15) == 0);
      r_eret  = ($urandom_range(0, 11) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_jr    = ($urandom_range(0, 7) == 0);
      r_jmp   = ($urandom_range(0, 7) == 0);
      r_br    = ($urandom_range(0, 3) == 0);
      r_ctrl  = ($urandom_range(0, 2) == 0);
      r_epc   = rand_target();
      r_bt    = rand_target();
      r_jt    = rand_target();
      r_jrt   = rand_target();
      reset = r_rst;
      drive(r_stall, r_exc, r_eret, r_br, r_jmp, r_jr, r_ctrl, r_epc, r_bt, r_jt, r_jrt);
      #1;
      check($sformatf("rnd%0d bd_o", n), {31'd0, bd_o}, {31'd0, r_ctrl && !r_exc && !r_eret});
      if (r_rst) begin
        m_pc = 32'h3000; m_cnt = 32'd0;
      end else if (r_exc) begin
        m_pc = 32'h4180;
      end else if (r_eret) begin
        m_pc = r_epc;
      end else if (!r_stall) begin
        m_cnt = m_cnt + 32'd1;
        m_pc  = r_jr ? r_jrt : r_jmp ? r_jt : r_br ? r_bt : m_pc + 32'd4;
      end
      @(posedge clk); #1;
      check_state($sformatf("rnd%0d", n), m_pc, m_cnt);
      $display("rnd %0d: pc_o=%h fetch_cnt=%0d", n, pc_o, fetch_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline. Owns the program counter and selects the next PC from sequential, branch, jump/jr, exception-entry and eret sources.
- Drives the instruction-memory address and checks the fetch address for AdEL.
- Presents the instruction, PC, ExCode and branch-delay flag to the IF/ID pipeline register that sits directly downstream.
- Keeps a retired-fetch counter for debug.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset
- EXC_ENTRY, 32'h0000_4180, exception/interrupt handler address
- IM_BASE, 32'h0000_3000, lowest legal fetch address
- IM_TOP, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard stall from ID; hold PC (IF/ID enable is its inverse)
- exc_req  in  1  CP0 exception/interrupt taken this cycle
- eret  in  1  eret committed this cycle
- epc  in  32  return address from CP0
- br_taken  in  1  ID branch condition true
- br_target  in  32  ID branch target
- jmp  in  1  ID j/jal
- jmp_target  in  32  ID {PC[31:28], idx, 2'b00}
- jr  in  1  ID jr/jalr
- jr_target  in  32  forwarded rs value
- is_ctrl_d  in  1  instruction in ID is a branch/jump (any, taken or not)
- im_addr  out  32  instruction memory address (= pc)
- im_rdata  in  32  instruction memory data (combinational read)
- instr_o  out  32  instruction to IF/ID
- pc_o  out  32  PC to IF/ID
- excode_o  out  7 [8:2]  ExcCode to IF/ID, 0 = none, 4 = AdEL
- bd_o  out  1  fetched instruction is a delay-slot instruction
- fetch_cnt  out  32  count of fetches accepted into IF/ID

Behaviour:
- State consists of a 32-bit PC register and a 32-bit fetch_cnt.
  - Reset: pc = PC_RESET and fetch_cnt = 0.
  - Outputs after reset: im_addr = pc_o = 0x3000, instr_o = im_rdata, excode_o = 0, bd_o = 0.
- Next-PC priority, evaluated each posedge, highest first:
  - 1. reset -> PC_RESET
  - 2. exc_req -> EXC_ENTRY
  - 3. eret -> epc
  - 4. stall -> hold pc
  - 5. jr -> jr_target
  - 6. jmp -> jmp_target
  - 7. br_taken -> br_target
  - 8. otherwise -> pc + 4
- exc_req and eret override stall; exc_req wins if asserted together with eret.
- Redirects (items 5-7) are ignored while stalled. ID keeps presenting them until the stall clears; the redirect takes effect on the first unstalled edge.
- Address check is combinational on the current pc. AdEL is flagged if pc[1:0] != 0, pc < IM_BASE or pc > IM_TOP. On AdEL:
  - excode_o = 7'd4
  - instr_o = 32'h0 (nop), so ID decodes nothing
  - im_addr still = pc; memory output is ignored
- No AdEL: excode_o = 0 and instr_o = im_rdata.
- bd_o = is_ctrl_d. The instruction fetched while ID holds a branch/jump is its delay slot. bd_o is forced to 0 in any cycle where exc_req or eret is asserted, because that fetch is flushed.
- pc_o = pc unconditionally, including under AdEL, so CP0 can record EPC/BadVAddr.
- fetch_cnt increments by 1 on an edge where !reset && !stall && !exc_req && !eret. It wraps 0xFFFF_FFFF -> 0.
- Latency: a redirect asserted in cycle N makes pc_o equal the target in cycle N+1. Zero-cycle combinational path from pc to instr_o.
- Arithmetic is 32-bit modular. pc + 4 from 0xFFFF_FFFC wraps to 0, which is then flagged AdEL.
- Reset mid-operation (stalled, or redirect pending): PC_RESET next edge and all pending requests dropped.

Test Plan:
- Reset, then 4 unstalled cycles -> pc_o 0x3000, 0x3004, 0x3008, 0x300C; fetch_cnt = 4; excode_o = 0.
- stall high 3 cycles at pc = 0x3010 with br_taken = 1, br_target = 0x3100 -> pc_o holds 0x3010 and fetch_cnt holds. Stall drops -> next pc_o = 0x3100.
- jr = 1 and br_taken = 1 same cycle, jr_target = 0x3200 -> pc_o = 0x3200.
- exc_req = 1 together with stall = 1 and eret = 1 -> pc_o = 0x4180 next cycle, bd_o = 0 that cycle, fetch_cnt unchanged.
- eret with epc = 0x3002 -> pc_o = 0x3002, excode_o = 4, instr_o = 0.
- pc runs 0x6FF8 -> 0x6FFC -> 0x7000: excode_o = 4 only at 0x7000.
- is_ctrl_d = 1 -> bd_o = 1 for the same-cycle fetch.
